// File: rtl/pulse_width_meter_pkg.sv
// Shared definitions for the pulse width meter: FSM state encoding and default counter width.
package pulse_width_meter_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_width_meter_sat_counter.sv
// Measurement counter: load-to-1 on restart, saturating increment, sticky saturation flag.
module pulse_width_meter_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  // sat only sets when an increment is actually clipped, so a count that lands exactly on max stays valid
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (load) begin
      cnt <= CNT_ONE;
      sat <= 1'b0;
    end else if (inc) begin
      if (cnt == CNT_MAX) begin
        sat <= 1'b1;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high time and period of a signal from edge-detector strobes and hands
// each completed {high, period, sat} result to a consumer over valid/ready.
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pos_edge,
  input  logic             neg_edge,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_sat,
  output logic             meas_lost
);

  state_t state, state_next;

  logic             evt_r, evt_f;
  logic             cnt_clear, cnt_load, cnt_inc;
  logic             capture_high, complete;
  logic [CNT_W-1:0] cnt;
  logic             cnt_sat;
  logic [CNT_W-1:0] high_r;

  // Simultaneous strobes are a glitch and count as no event
  assign evt_r = pos_edge & ~neg_edge;
  assign evt_f = neg_edge & ~pos_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (evt_r) state_next = ST_HIGH;
        ST_HIGH: if (evt_f) state_next = ST_LOW;
        ST_LOW:  if (evt_r) state_next = ST_HIGH;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;
    capture_high = 1'b0;
    complete     = 1'b0;
    if (!en) begin
      cnt_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: cnt_load = evt_r;
        ST_HIGH: begin
          cnt_load     = evt_r;
          cnt_inc      = !evt_r;
          capture_high = evt_f;
        end
        ST_LOW: begin
          cnt_load = evt_r;
          cnt_inc  = !evt_r;
          complete = evt_r;
        end
        default: cnt_clear = 1'b1;
      endcase
    end
  end

  pulse_width_meter_sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .sat   (cnt_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      high_r <= '0;
    end else if (capture_high) begin
      high_r <= cnt;
    end
  end

  // A completion is only accepted into the result registers when they are free or being drained this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      meas_valid <= 1'b0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_sat   <= 1'b0;
      meas_lost  <= 1'b0;
    end else begin
      meas_lost <= 1'b0;
      if (complete && (!meas_valid || meas_ready)) begin
        meas_valid <= 1'b1;
        high_cnt   <= high_r;
        period_cnt <= cnt;
        meas_sat   <= cnt_sat;
      end else if (complete) begin
        meas_lost <= 1'b1;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench: drives identical strobes into a 16-bit and a 4-bit meter and checks results.
module tb_pulse_width_meter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        pos_edge;
  logic        neg_edge;
  logic        meas_ready;

  logic        v16, s16, l16;
  logic [15:0] h16, p16;
  logic        v4, s4, l4;
  logic [3:0]  h4, p4;

  int checks;
  int errors;

  pulse_width_meter dut_w16 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pos_edge   (pos_edge),
    .neg_edge   (neg_edge),
    .meas_valid (v16),
    .meas_ready (meas_ready),
    .high_cnt   (h16),
    .period_cnt (p16),
    .meas_sat   (s16),
    .meas_lost  (l16)
  );

  pulse_width_meter #(
    .CNT_W(4)
  ) dut_w4 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pos_edge   (pos_edge),
    .neg_edge   (neg_edge),
    .meas_valid (v4),
    .meas_ready (meas_ready),
    .high_cnt   (h4),
    .period_cnt (p4),
    .meas_sat   (s4),
    .meas_lost  (l4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle with the given strobes; returns 1 time unit after the edge
  task automatic applyStimulus(input logic p, input logic n);
    pos_edge = p;
    neg_edge = n;
    @(posedge clk);
    #1;
    pos_edge = 1'b0;
    neg_edge = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    en = 1'b1;
    pos_edge = 1'b0;
    neg_edge = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    meas_ready = 1'b0;

    $display("[TB] reset state");
    resetDut();
    checkOutput("rst_valid", v16, 0);
    checkOutput("rst_high", h16, 0);
    checkOutput("rst_period", p16, 0);
    checkOutput("rst_sat", s16, 0);
    checkOutput("rst_lost", l16, 0);
    checkOutput("rst_valid_w4", v4, 0);
    applyStimulus(1'b0, 1'b1);
    idle(3);
    checkOutput("idle_neg_no_result", v16, 0);

    $display("[TB] single measurement");
    meas_ready = 1'b1;
    applyStimulus(1'b1, 1'b0);
    idle(3);
    applyStimulus(1'b0, 1'b1);
    idle(5);
    checkOutput("basic_not_yet_valid", v16, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("basic_valid", v16, 1);
    checkOutput("basic_high", h16, 4);
    checkOutput("basic_period", p16, 10);
    checkOutput("basic_sat", s16, 0);
    checkOutput("basic_high_w4", h4, 4);
    checkOutput("basic_period_w4", p4, 10);
    idle(1);
    checkOutput("basic_consumed", v16, 0);

    $display("[TB] square wave 3/5");
    resetDut();
    meas_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (k > 0) begin
        checkOutput("sq_valid", v16, 1);
        checkOutput("sq_high", h16, 3);
        checkOutput("sq_period", p16, 8);
        checkOutput("sq_lost", l16, 0);
      end
      idle(2);
      applyStimulus(1'b0, 1'b1);
      checkOutput("sq_drained", v16, 0);
      checkOutput("sq_lost_mid", l16, 0);
      idle(4);
    end

    $display("[TB] back-pressure");
    resetDut();
    meas_ready = 1'b0;
    applyStimulus(1'b1, 1'b0);
    idle(1);
    applyStimulus(0, 1);
    idle(3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("bp_valid", v16, 1);
    checkOutput("bp_high", h16, 2);
    checkOutput("bp_period", p16, 6);
    checkOutput("bp_lost_first", l16, 0);
    idle(3);
    applyStimulus(1'b0, 1'b1);
    checkOutput("bp_hold_valid", v16, 1);
    checkOutput("bp_hold_high", h16, 2);
    idle(4);
    applyStimulus(1'b1, 1'b0);
    checkOutput("bp_lost_pulse", l16, 1);
    checkOutput("bp_still_valid", v16, 1);
    checkOutput("bp_kept_high", h16, 2);
    checkOutput("bp_kept_period", p16, 6);
    checkOutput("bp_lost_w4", l4, 1);
    idle(1);
    checkOutput("bp_lost_single", l16, 0);
    checkOutput("bp_kept_period2", p16, 6);
    meas_ready = 1'b1;
    idle(1);
    checkOutput("bp_accepted", v16, 0);

    $display("[TB] saturation");
    resetDut();
    meas_ready = 1'b1;
    applyStimulus(1'b1, 1'b0);
    idle(19);
    applyStimulus(1'b0, 1'b1);
    idle(4);
    applyStimulus(1'b1, 1'b0);
    checkOutput("sat_valid_w4", v4, 1);
    checkOutput("sat_high_w4", h4, 15);
    checkOutput("sat_period_w4", p4, 15);
    checkOutput("sat_flag_w4", s4, 1);
    checkOutput("sat_high_w16", h16, 20);
    checkOutput("sat_period_w16", p16, 25);
    checkOutput("sat_flag_w16", s16, 0);
    idle(2);
    applyStimulus(1'b0, 1'b1);
    idle(4);
    applyStimulus(1'b1, 1'b0);
    checkOutput("sat_recover_valid", v4, 1);
    checkOutput("sat_recover_high", h4, 3);
    checkOutput("sat_recover_period", p4, 8);
    checkOutput("sat_recover_flag", s4, 0);

    $display("[TB] missing fall, glitch and aborts");
    resetDut();
    meas_ready = 1'b1;
    applyStimulus(1'b1, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_no_result", v16, 0);
    idle(1);
    applyStimulus(1'b0, 1'b1);
    idle(1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("glitch_no_result", v16, 0);
    idle(1);
    meas_ready = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_valid", v16, 1);
    checkOutput("restart_high", h16, 2);
    checkOutput("restart_period", p16, 6);

    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    meas_ready = 1'b1;
    checkOutput("midrst_valid", v16, 0);
    checkOutput("midrst_high", h16, 0);
    checkOutput("midrst_period", p16, 0);
    applyStimulus(1'b0, 1'b1);
    idle(2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("midrst_no_result", v16, 0);

    idle(1);
    en = 1'b0;
    idle(1);
    en = 1'b1;
    applyStimulus(1'b0, 1'b1);
    idle(2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("en_abort_no_result", v16, 0);
    idle(2);
    applyStimulus(1'b0, 1'b1);
    idle(2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("en_resume_valid", v16, 1);
    checkOutput("en_resume_high", h16, 3);
    checkOutput("en_resume_period", p16, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
